// File: rtl/dbr_pkg.sv
// Shared types for the delayed-branch scheduler: condition codes, FSM states,
// queue entry metadata and the condition evaluator.
package dbr_pkg;

  typedef enum logic [2:0] {
    NV = 3'd0,
    AL = 3'd1,
    EQ = 3'd2,
    NE = 3'd3,
    LT = 3'd4,
    LE = 3'd5,
    GT = 3'd6,
    GE = 3'd7
  } cond_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    HALTED   = 2'd2
  } state_t;

  // Per-entry metadata; the destination rides alongside it so AW stays a parameter.
  typedef struct packed {
    cond_t      cond;
    logic       halt;
    logic [1:0] lane;
  } entry_t;

  localparam int         ENTRY_W = $bits(entry_t);
  localparam logic [1:0] LANE_P0 = 2'b01;
  localparam logic [1:0] LANE_P1 = 2'b10;

  function automatic logic cond_met(cond_t c, logic n, logic v, logic z);
    logic lt;
    lt = n ^ v;
    case (c)
      NV:      cond_met = 1'b0;
      AL:      cond_met = 1'b1;
      EQ:      cond_met = z;
      NE:      cond_met = !z;
      LT:      cond_met = lt;
      LE:      cond_met = z | lt;
      GT:      cond_met = !z & !lt;
      GE:      cond_met = !lt;
      default: cond_met = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dbr_fifo.sv
// Dual-write, single-pop circular buffer with synchronous clear; lane 0 lands before lane 1.
// Writes and pop take effect at the next edge; the caller gates writes against count.
module dbr_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          wr0,
  input  logic [W-1:0]  wr0_dat,
  input  logic          wr1,
  input  logic [W-1:0]  wr1_dat,
  input  logic          pop,
  output logic [W-1:0]  head_dat,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW-1:0] wr1_idx;
  logic [1:0]    n_wr;

  assign n_wr     = {1'b0, wr0} + {1'b0, wr1};
  assign wr1_idx  = wr0 ? tail + PW'(1) : tail;
  assign head_dat = mem[head];

  always_ff @(posedge clk) begin
    if (wr0) mem[tail]    <= wr0_dat;
    if (wr1) mem[wr1_idx] <= wr1_dat;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (clr) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      tail  <= tail + PW'(n_wr);
      head  <= head + PW'(pop);
      count <= count + CW'(n_wr) - CW'(pop);
    end
  end

endmodule

// File: rtl/dbr_sched.sv
// Delayed-branch resolution scheduler: queues p0/p1 branch halves, resolves the head on flags_valid.
// Results are registered one cycle after resolution; redirect holds until redirect_ready.
module dbr_sched
  import dbr_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enq_p0_valid,
  input  logic [AW-1:0] enq_p0_dest,
  input  logic [2:0]    enq_p0_cond,
  input  logic          enq_p0_halt,
  input  logic          enq_p1_valid,
  input  logic [AW-1:0] enq_p1_dest,
  input  logic [2:0]    enq_p1_cond,
  input  logic          enq_p1_halt,
  input  logic          flags_valid,
  input  logic          N,
  input  logic          V,
  input  logic          Z,
  input  logic          redirect_ready,
  output logic          full,
  output logic          empty,
  output logic          redirect_valid,
  output logic [AW:0]   redirect_pc,
  output logic          redirect_odd,
  output logic          flush_pipe,
  output logic [1:0]    do_delayed_lane,
  output logic          halted,
  output logic [AW-1:0] halt_addr,
  output logic          spurious_resolve
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int W  = AW + ENTRY_W;

  state_t        state, state_nxt;
  logic [CW-1:0] count;
  logic [W-1:0]  head_dat, wr0_dat, wr1_dat;
  logic [AW-1:0] head_dest;
  entry_t        head_ent, ent0, ent1;
  logic          enq_ok, wr0, wr1, pop, clr, taken;

  logic          rv_nxt, odd_nxt, flush_nxt, halted_nxt, spur_nxt;
  logic [AW:0]   pc_nxt;
  logic [1:0]    lane_nxt;
  logic [AW-1:0] haddr_nxt;

  assign full  = (count > CW'(DEPTH - 2));
  assign empty = (count == '0);

  always_comb begin
    ent0 = '{cond: cond_t'(enq_p0_cond), halt: enq_p0_halt, lane: LANE_P0};
    ent1 = '{cond: cond_t'(enq_p1_cond), halt: enq_p1_halt, lane: LANE_P1};
  end

  assign wr0_dat               = {enq_p0_dest, ent0};
  assign wr1_dat               = {enq_p1_dest, ent1};
  assign {head_dest, head_ent} = head_dat;

  assign enq_ok = (state == IDLE) && !full;
  assign wr0    = enq_ok && enq_p0_valid;
  assign wr1    = enq_ok && enq_p1_valid;
  assign taken  = (state == IDLE) && flags_valid && !empty && cond_met(head_ent.cond, N, V, Z);
  assign pop    = (state == IDLE) && flags_valid && !empty && !taken;
  // Everything queued behind a taken branch is wrong-path, so the queue is dropped wholesale.
  assign clr    = ((state == REDIRECT) && redirect_ready) || (state == HALTED) ||
                  (taken && head_ent.halt);

  dbr_fifo #(.DEPTH(DEPTH), .W(W)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .wr0      (wr0),
    .wr0_dat  (wr0_dat),
    .wr1      (wr1),
    .wr1_dat  (wr1_dat),
    .pop      (pop),
    .head_dat (head_dat),
    .count    (count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    rv_nxt     = redirect_valid;
    pc_nxt     = redirect_pc;
    odd_nxt    = redirect_odd;
    lane_nxt   = do_delayed_lane;
    flush_nxt  = 1'b0;
    halted_nxt = halted;
    haddr_nxt  = halt_addr;
    spur_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (flags_valid && empty) begin
          spur_nxt = 1'b1;
        end else if (taken) begin
          flush_nxt = 1'b1;
          if (head_ent.halt) begin
            state_nxt  = HALTED;
            halted_nxt = 1'b1;
            haddr_nxt  = head_dest;
          end else begin
            state_nxt = REDIRECT;
            rv_nxt    = 1'b1;
            pc_nxt    = {1'b0, head_dest[AW-1:1], 1'b0};
            odd_nxt   = head_dest[0];
            lane_nxt  = head_ent.lane;
          end
        end
      end
      REDIRECT: begin
        spur_nxt = flags_valid;
        if (redirect_ready) begin
          state_nxt = IDLE;
          rv_nxt    = 1'b0;
          pc_nxt    = '0;
          odd_nxt   = 1'b0;
          lane_nxt  = '0;
        end
      end
      HALTED: state_nxt = HALTED;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      redirect_valid   <= 1'b0;
      redirect_pc      <= '0;
      redirect_odd     <= 1'b0;
      do_delayed_lane  <= '0;
      flush_pipe       <= 1'b0;
      halted           <= 1'b0;
      halt_addr        <= '0;
      spurious_resolve <= 1'b0;
    end else begin
      redirect_valid   <= rv_nxt;
      redirect_pc      <= pc_nxt;
      redirect_odd     <= odd_nxt;
      do_delayed_lane  <= lane_nxt;
      flush_pipe       <= flush_nxt;
      halted           <= halted_nxt;
      halt_addr        <= haddr_nxt;
      spurious_resolve <= spur_nxt;
    end
  end

endmodule

// File: tb/tb_dbr_sched.sv
// Directed bench for dbr_sched: reset, not-taken pop, redirect hold, halt, fill/wrap order, spurious.
module tb_dbr_sched;
  import dbr_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enq_p0_valid = 1'b0, enq_p1_valid = 1'b0;
  logic [7:0] enq_p0_dest = '0, enq_p1_dest = '0;
  logic [2:0] enq_p0_cond = '0, enq_p1_cond = '0;
  logic       enq_p0_halt = 1'b0, enq_p1_halt = 1'b0;
  logic       flags_valid = 1'b0, n_f = 1'b0, v_f = 1'b0, z_f = 1'b0;
  logic       redirect_ready = 1'b0;

  logic       full, empty, redirect_valid, redirect_odd, flush_pipe, halted, spurious_resolve;
  logic [8:0] redirect_pc;
  logic [1:0] do_delayed_lane;
  logic [7:0] halt_addr;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dbr_sched #(.DEPTH(4), .AW(8)) dut (
    .clk              (clk),
    .rst              (rst),
    .enq_p0_valid     (enq_p0_valid),
    .enq_p0_dest      (enq_p0_dest),
    .enq_p0_cond      (enq_p0_cond),
    .enq_p0_halt      (enq_p0_halt),
    .enq_p1_valid     (enq_p1_valid),
    .enq_p1_dest      (enq_p1_dest),
    .enq_p1_cond      (enq_p1_cond),
    .enq_p1_halt      (enq_p1_halt),
    .flags_valid      (flags_valid),
    .N                (n_f),
    .V                (v_f),
    .Z                (z_f),
    .redirect_ready   (redirect_ready),
    .full             (full),
    .empty            (empty),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .redirect_odd     (redirect_odd),
    .flush_pipe       (flush_pipe),
    .do_delayed_lane  (do_delayed_lane),
    .halted           (halted),
    .halt_addr        (halt_addr),
    .spurious_resolve (spurious_resolve)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic enq0(input logic [7:0] d, input cond_t c, input logic h);
    enq_p0_valid = 1'b1; enq_p0_dest = d; enq_p0_cond = c; enq_p0_halt = h;
  endtask

  task automatic enq1(input logic [7:0] d, input cond_t c, input logic h);
    enq_p1_valid = 1'b1; enq_p1_dest = d; enq_p1_cond = c; enq_p1_halt = h;
  endtask

  task automatic idle_in();
    enq_p0_valid = 1'b0; enq_p1_valid = 1'b0; enq_p0_halt = 1'b0; enq_p1_halt = 1'b0;
    flags_valid = 1'b0; redirect_ready = 1'b0;
  endtask

  task automatic flags(input logic n, input logic v, input logic z);
    flags_valid = 1'b1; n_f = n; v_f = v; z_f = z;
  endtask

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_rv", 32'(redirect_valid), 0);
    chk("rst_pc", 32'(redirect_pc), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_haddr", 32'(halt_addr), 0);
    chk("rst_flush", 32'(flush_pipe), 0);
    rst = 1'b1;
    tick();

    // Async reset mid-run drops a queued entry without a clock edge
    enq0(8'h33, AL, 1'b0); tick(); idle_in();
    chk("mid_empty0", 32'(empty), 0);
    rst = 1'b0; #2;
    chk("mid_rst_empty", 32'(empty), 1);
    rst = 1'b1;
    tick();

    // Not-taken EQ with Z=0 pops silently
    enq0(8'h12, EQ, 1'b0); tick(); idle_in();
    chk("nt_empty0", 32'(empty), 0);
    flags(1'b0, 1'b0, 1'b0); tick(); idle_in();
    chk("nt_empty", 32'(empty), 1);
    chk("nt_rv", 32'(redirect_valid), 0);
    chk("nt_flush", 32'(flush_pipe), 0);

    // Taken AL, odd destination, redirect held until ready
    enq0(8'h11, AL, 1'b0); tick(); idle_in();
    flags(1'b0, 1'b0, 1'b0); tick(); idle_in();
    chk("al_rv", 32'(redirect_valid), 1);
    chk("al_pc", 32'(redirect_pc), 32'h010);
    chk("al_odd", 32'(redirect_odd), 1);
    chk("al_lane", 32'(do_delayed_lane), 2'b01);
    chk("al_flush", 32'(flush_pipe), 1);
    for (int i = 0; i < 3; i++) begin
      if (i == 1) flags(1'b0, 1'b0, 1'b1);
      tick(); idle_in();
      chk("hold_rv", 32'(redirect_valid), 1);
      chk("hold_pc", 32'(redirect_pc), 32'h010);
      chk("hold_flush", 32'(flush_pipe), 0);
      chk("hold_spur", 32'(spurious_resolve), (i == 1) ? 1 : 0);
    end
    redirect_ready = 1'b1; tick(); idle_in();
    chk("acc_rv", 32'(redirect_valid), 0);
    chk("acc_empty", 32'(empty), 1);

    // Dual enqueue, LT taken with N=1 V=0; younger p1 entry discarded on accept
    enq0(8'h20, LT, 1'b0); enq1(8'h30, GE, 1'b0); tick(); idle_in();
    flags(1'b1, 1'b0, 1'b0); tick(); idle_in();
    chk("lt_rv", 32'(redirect_valid), 1);
    chk("lt_pc", 32'(redirect_pc), 32'h020);
    chk("lt_odd", 32'(redirect_odd), 0);
    chk("lt_lane", 32'(do_delayed_lane), 2'b01);
    chk("lt_empty", 32'(empty), 0);
    redirect_ready = 1'b1; tick(); idle_in();
    chk("lt_acc_rv", 32'(redirect_valid), 0);
    chk("lt_acc_empty", 32'(empty), 1);

    // flags_valid while empty
    flags(1'b0, 1'b0, 1'b0); tick(); idle_in();
    chk("spur_empty", 32'(spurious_resolve), 1);
    chk("spur_rv", 32'(redirect_valid), 0);
    tick();
    chk("spur_clear", 32'(spurious_resolve), 0);

    // Fill, drop-while-full, mixed pop+enqueue, pointer wrap; alternating EQ/NE makes misordering redirect
    enq0(8'h01, EQ, 1'b0); enq1(8'h02, NE, 1'b0); tick(); idle_in();
    chk("f2_full", 32'(full), 0);
    enq0(8'h03, EQ, 1'b0); tick(); idle_in();
    chk("f3_full", 32'(full), 1);
    enq0(8'h7E, AL, 1'b0); tick(); idle_in();
    chk("drop_full", 32'(full), 1);
    flags(1'b0, 1'b0, 1'b0); tick(); idle_in();
    chk("popA_full", 32'(full), 0);
    chk("popA_rv", 32'(redirect_valid), 0);
    flags(1'b0, 1'b0, 1'b1); enq0(8'h04, NE, 1'b0); enq1(8'h05, EQ, 1'b0); tick(); idle_in();
    chk("popB_full", 32'(full), 1);
    chk("popB_rv", 32'(redirect_valid), 0);
    flags(1'b0, 1'b0, 1'b0); tick(); idle_in();
    chk("popC_full", 32'(full), 0);
    chk("popC_rv", 32'(redirect_valid), 0);
    enq0(8'h06, NE, 1'b0); enq1(8'h0B, AL, 1'b0); tick(); idle_in();
    chk("f4_full", 32'(full), 1);
    flags(1'b0, 1'b0, 1'b1); tick(); idle_in();
    chk("popD_rv", 32'(redirect_valid), 0);
    flags(1'b0, 1'b0, 1'b0); tick(); idle_in();
    chk("popE_rv", 32'(redirect_valid), 0);
    flags(1'b0, 1'b0, 1'b1); tick(); idle_in();
    chk("popF_rv", 32'(redirect_valid), 0);
    chk("popF_empty", 32'(empty), 0);
    chk("popF_full", 32'(full), 0);
    flags(1'b1, 1'b1, 1'b1); tick(); idle_in();
    chk("wrap_rv", 32'(redirect_valid), 1);
    chk("wrap_pc", 32'(redirect_pc), 32'h00A);
    chk("wrap_odd", 32'(redirect_odd), 1);
    chk("wrap_lane", 32'(do_delayed_lane), 2'b10);
    redirect_ready = 1'b1; tick(); idle_in();
    chk("wrap_acc_empty", 32'(empty), 1);

    // HALT from lane 1, then absorbing until reset
    enq1(8'h45, AL, 1'b1); tick(); idle_in();
    flags(1'b0, 1'b0, 1'b0); tick(); idle_in();
    chk("h_halted", 32'(halted), 1);
    chk("h_addr", 32'(halt_addr), 32'h45);
    chk("h_flush", 32'(flush_pipe), 1);
    chk("h_rv", 32'(redirect_valid), 0);
    chk("h_empty", 32'(empty), 1);
    enq0(8'h12, AL, 1'b0); flags(1'b0, 1'b0, 1'b0); tick(); idle_in();
    chk("h_flush_off", 32'(flush_pipe), 0);
    tick();
    chk("h_sticky", 32'(halted), 1);
    chk("h_ign_empty", 32'(empty), 1);
    chk("h_ign_rv", 32'(redirect_valid), 0);
    chk("h_ign_addr", 32'(halt_addr), 32'h45);
    rst = 1'b0; #2;
    chk("h_rst_halted", 32'(halted), 0);
    chk("h_rst_addr", 32'(halt_addr), 0);
    chk("h_rst_empty", 32'(empty), 1);
    rst = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
